// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared definitions for the sprite motion controller: update-sequence
// state encodings and the default coordinate width.
package sprite_motion_ctrl_pkg;

  localparam int unsigned CORDW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE_X = 2'd1,
    ST_MOVE_Y = 2'd2,
    ST_ANIM   = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position step with edge reflection (combinational).
// Ports:
//   i_pos        current position (signed)
//   i_dir        0 = increasing, 1 = decreasing
//   i_spd        unsigned step magnitude
//   i_max        upper position limit (lower limit is 0)
//   o_next_pos_c stepped / clamped position
//   o_next_dir_c direction after a possible reflection
//   o_hit_c      a reflection occurred
module sprite_axis_step
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int unsigned CORDW = CORDW_DEF,
  parameter int unsigned SPDW  = 4
) (
  input  logic signed [CORDW-1:0] i_pos,
  input  logic                    i_dir,
  input  logic        [SPDW-1:0]  i_spd,
  input  logic signed [CORDW-1:0] i_max,
  output logic signed [CORDW-1:0] o_next_pos_c,
  output logic                    o_next_dir_c,
  output logic                    o_hit_c
);

  // One extra bit so a step past either limit cannot wrap.
  logic signed [CORDW:0] w_pos_ext;
  logic signed [CORDW:0] w_spd_ext;
  logic signed [CORDW:0] w_max_ext;
  logic signed [CORDW:0] w_n;

  assign w_pos_ext = {i_pos[CORDW-1], i_pos};
  assign w_spd_ext = {{(CORDW+1-SPDW){1'b0}}, i_spd};
  assign w_max_ext = {i_max[CORDW-1], i_max};
  assign w_n       = i_dir ? (w_pos_ext - w_spd_ext) : (w_pos_ext + w_spd_ext);

  // Landing exactly on a limit keeps the direction; only overshoot reflects.
  always_comb begin
    o_next_pos_c = w_n[CORDW-1:0];
    o_next_dir_c = i_dir;
    o_hit_c      = 1'b0;
    if (w_n > w_max_ext) begin
      o_next_pos_c = i_max;
      o_next_dir_c = 1'b1;
      o_hit_c      = 1'b1;
    end else if (w_n[CORDW]) begin
      o_next_pos_c = '0;
      o_next_dir_c = 1'b0;
      o_hit_c      = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position / animation controller. On a frame strobe it
// steps x then y by the latched velocity (reflecting at screen edges) and
// then advances the animation index, one cycle per step.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame, en           start-of-vblank strobe, motion enable
//   load, ld_x, ld_y    position load (IDLE only), clears directions
//   spd_x, spd_y        step magnitudes, latched on accepted frame
//   sprx, spry          sprite position to the sprite engine
//   dir_x, dir_y        0 = +axis, 1 = -axis
//   anim_idx            animation frame index
//   bounce, done        1-cycle pulses at the end of an update
//   busy                update sequence in progress
module sprite_motion_ctrl
  import sprite_motion_ctrl_pkg::*;
#(
  parameter int unsigned CORDW       = CORDW_DEF,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned SPR_WIDTH   = 8,
  parameter int unsigned SPR_HEIGHT  = 8,
  parameter int unsigned SPR_SCALE   = 0,
  parameter int unsigned SPDW        = 4,
  parameter int unsigned ANIM_FRAMES = 4,
  parameter int unsigned ANIM_DIV    = 8,
  parameter int          SX_INIT     = 0,
  parameter int          SY_INIT     = 0,
  localparam int unsigned AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [CORDW-1:0] ld_x,
  input  logic signed [CORDW-1:0] ld_y,
  input  logic        [SPDW-1:0]  spd_x,
  input  logic        [SPDW-1:0]  spd_y,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic                    dir_x,
  output logic                    dir_y,
  output logic        [AW-1:0]    anim_idx,
  output logic                    bounce,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int          XMAX = int'(H_RES) - int'(SPR_WIDTH << SPR_SCALE);
  localparam int          YMAX = int'(V_RES) - int'(SPR_HEIGHT << SPR_SCALE);

  state_t                  r_state;
  logic signed [CORDW-1:0] r_sprx;
  logic signed [CORDW-1:0] r_spry;
  logic                    r_dir_x;
  logic                    r_dir_y;
  logic        [SPDW-1:0]  r_spd_x;
  logic        [SPDW-1:0]  r_spd_y;
  logic        [AW-1:0]    r_anim;
  logic        [DW-1:0]    r_div;
  logic                    r_bflag;
  logic                    r_bounce;
  logic                    r_busy;
  logic                    r_done;

  logic signed [CORDW-1:0] w_pos;
  logic                    w_dir;
  logic        [SPDW-1:0]  w_spd;
  logic signed [CORDW-1:0] w_max;
  logic signed [CORDW-1:0] w_next_pos;
  logic                    w_next_dir;
  logic                    w_hit;

  // Single axis stepper shared by both moves: y operands in MOVE_Y, x otherwise.
  assign w_pos = (r_state == ST_MOVE_Y) ? r_spry  : r_sprx;
  assign w_dir = (r_state == ST_MOVE_Y) ? r_dir_y : r_dir_x;
  assign w_spd = (r_state == ST_MOVE_Y) ? r_spd_y : r_spd_x;
  assign w_max = (r_state == ST_MOVE_Y) ? CORDW'(YMAX) : CORDW'(XMAX);

  sprite_axis_step #(
    .CORDW (CORDW),
    .SPDW  (SPDW)
  ) u_axis_step (
    .i_pos        (w_pos),
    .i_dir        (w_dir),
    .i_spd        (w_spd),
    .i_max        (w_max),
    .o_next_pos_c (w_next_pos),
    .o_next_dir_c (w_next_dir),
    .o_hit_c      (w_hit)
  );

  // Update sequencer; position only changes here, never mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sprx   <= CORDW'(SX_INIT);
      r_spry   <= CORDW'(SY_INIT);
      r_dir_x  <= 1'b0;
      r_dir_y  <= 1'b0;
      r_spd_x  <= '0;
      r_spd_y  <= '0;
      r_anim   <= '0;
      r_div    <= '0;
      r_bflag  <= 1'b0;
      r_bounce <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_bounce <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Load wins over a coincident frame strobe.
          if (load) begin
            r_sprx  <= ld_x;
            r_spry  <= ld_y;
            r_dir_x <= 1'b0;
            r_dir_y <= 1'b0;
          end else if (frame && en) begin
            r_spd_x <= spd_x;
            r_spd_y <= spd_y;
            r_busy  <= 1'b1;
            r_state <= ST_MOVE_X;
          end
        end
        ST_MOVE_X: begin
          r_sprx  <= w_next_pos;
          r_dir_x <= w_next_dir;
          r_bflag <= r_bflag | w_hit;
          r_state <= ST_MOVE_Y;
        end
        ST_MOVE_Y: begin
          r_spry  <= w_next_pos;
          r_dir_y <= w_next_dir;
          r_bflag <= r_bflag | w_hit;
          r_state <= ST_ANIM;
        end
        ST_ANIM: begin
          if (r_div == DW'(ANIM_DIV - 1)) begin
            r_div  <= '0;
            r_anim <= (r_anim == AW'(ANIM_FRAMES - 1)) ? '0 : r_anim + AW'(1);
          end else begin
            r_div <= r_div + DW'(1);
          end
          r_done   <= 1'b1;
          r_bounce <= r_bflag;
          r_bflag  <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sprx     = r_sprx;
  assign spry     = r_spry;
  assign dir_x    = r_dir_x;
  assign dir_y    = r_dir_y;
  assign anim_idx = r_anim;
  assign bounce   = r_bounce;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl (640x480, 8x8 sprite scaled x4,
// 4 animation frames, 2 video frames per animation step).
module tb_sprite_motion_ctrl;

  localparam int XMAX = 608;
  localparam int YMAX = 448;
  localparam int NFR  = 4;
  localparam int NDIV = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame;
  logic               en;
  logic               load;
  logic signed [15:0] ld_x;
  logic signed [15:0] ld_y;
  logic        [3:0]  spd_x;
  logic        [3:0]  spd_y;
  logic signed [15:0] sprx;
  logic signed [15:0] spry;
  logic               dir_x;
  logic               dir_y;
  logic        [1:0]  anim_idx;
  logic               bounce;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(
    .CORDW(16), .H_RES(640), .V_RES(480), .SPR_WIDTH(8), .SPR_HEIGHT(8),
    .SPR_SCALE(2), .SPDW(4), .ANIM_FRAMES(NFR), .ANIM_DIV(NDIV),
    .SX_INIT(0), .SY_INIT(0)
  ) dut (
    .clk(clk), .rst(rst), .frame(frame), .en(en), .load(load),
    .ld_x(ld_x), .ld_y(ld_y), .spd_x(spd_x), .spd_y(spd_y),
    .sprx(sprx), .spry(spry), .dir_x(dir_x), .dir_y(dir_y),
    .anim_idx(anim_idx), .bounce(bounce), .busy(busy), .done(done)
  );

  typedef struct {
    int x; int y; bit dx; bit dy; int anim; bit b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state of the controller.
  int m_x, m_y, m_anim, m_div;
  bit m_dx, m_dy;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void axis(inout int p, inout bit d, input int s,
                               input int mx, inout bit b);
    int n;
    n = d ? p - s : p + s;
    if (n > mx) begin p = mx; d = 1'b1; b = 1'b1; end
    else if (n < 0) begin p = 0; d = 1'b0; b = 1'b1; end
    else p = n;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_anim = 0; m_div = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; frame = 1'b0; load = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    chk("rst_sprx", sprx, 0);   chk("rst_spry", spry, 0);
    chk("rst_dirx", dir_x, 0);  chk("rst_diry", dir_y, 0);
    chk("rst_anim", anim_idx, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_bounce", bounce, 0);
  endtask

  task automatic do_load(input int x, input int y);
    @(negedge clk); load = 1'b1; ld_x = 16'(x); ld_y = 16'(y);
    @(negedge clk); load = 1'b0;
    m_x = x; m_y = y; m_dx = 0; m_dy = 0;
    chk("load_sprx", sprx, m_x); chk("load_spry", spry, m_y);
    chk("load_dirx", dir_x, 0);  chk("load_diry", dir_y, 0);
    chk("load_busy", busy, 0);
  endtask

  // One update; poke=1 also fires frame+load while busy (both must be ignored).
  task automatic do_frame(input int sx, input int sy, input bit poke);
    exp_t e;
    bit   b;
    int   waited;
    b = 1'b0;
    @(negedge clk); spd_x = 4'(sx); spd_y = 4'(sy); frame = 1'b1;
    axis(m_x, m_dx, sx, XMAX, b);
    axis(m_y, m_dy, sy, YMAX, b);
    if (m_div == NDIV - 1) begin
      m_div  = 0;
      m_anim = (m_anim == NFR - 1) ? 0 : m_anim + 1;
    end else m_div++;
    e = '{m_x, m_y, m_dx, m_dy, m_anim, b};
    sb.push_back(e);
    @(negedge clk); frame = 1'b0; spd_x = 4'd0; spd_y = 4'd0;
    chk("busy_n1", busy, 1);
    if (poke) begin
      frame = 1'b1; load = 1'b1; ld_x = 16'sd77; ld_y = 16'sd77;
    end
    @(negedge clk); frame = 1'b0; load = 1'b0;
    chk("sprx_n2", sprx, e.x);
    chk("busy_n2", busy, 1);
    @(negedge clk);
    chk("spry_n3", spry, e.y);
    @(negedge clk);
    waited = 0;
    while (done !== 1'b1 && waited < 8) begin
      @(negedge clk); waited++;
    end
    chk("done_latency", waited, 0);
    e = sb.pop_front();
    if (done === 1'b1) begin
      chk("sb_sprx", sprx, e.x);      chk("sb_spry", spry, e.y);
      chk("sb_dirx", dir_x, e.dx);    chk("sb_diry", dir_y, e.dy);
      chk("sb_anim", anim_idx, e.anim);
      chk("sb_bounce", bounce, e.b);
      chk("sb_busy", busy, 0);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("bounce_pulse", bounce, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; frame = 1'b0; en = 1'b1; load = 1'b0;
    ld_x = '0; ld_y = '0; spd_x = '0; spd_y = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic step.
    do_load(100, 50);
    do_frame(3, 2, 1'b0);

    // Landing exactly on the limits keeps direction; speed 0 holds position.
    do_load(600, 440);
    do_frame(8, 8, 1'b0);
    do_frame(0, 0, 1'b0);

    // Overshoot at the high edge reflects.
    do_load(606, 446);
    do_frame(4, 4, 1'b0);

    // Travel back to the low edge and reflect there.
    for (int i = 0; i < 44; i++) do_frame(15, 15, 1'b0);

    // Negative start clamps to 0; next step proceeds positively.
    do_load(-20, -3);
    do_frame(5, 5, 1'b0);
    do_frame(5, 5, 1'b0);

    // Out-of-range high start clamps on the first update, even at speed 0.
    do_load(700, 500);
    do_frame(0, 0, 1'b0);

    // Animation cadence from reset, then en=0 hold.
    do_reset();
    do_load(10, 10);
    for (int i = 0; i < 10; i++) do_frame(1, 1, 1'b0);
    en = 1'b0;
    @(negedge clk); frame = 1'b1; spd_x = 4'd5; spd_y = 4'd5;
    @(negedge clk); frame = 1'b0;
    chk("en0_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("en0_sprx", sprx, m_x); chk("en0_spry", spry, m_y);
    chk("en0_anim", anim_idx, m_anim); chk("en0_done", done, 0);
    do_load(20, 30);
    en = 1'b1;
    do_frame(2, 2, 1'b0);

    // Frame coincident with load: load wins, no update starts.
    @(negedge clk); frame = 1'b1; load = 1'b1; ld_x = 16'sd300; ld_y = 16'sd200;
    spd_x = 4'd5; spd_y = 4'd5;
    @(negedge clk); frame = 1'b0; load = 1'b0;
    m_x = 300; m_y = 200; m_dx = 0; m_dy = 0;
    chk("fl_sprx", sprx, 300); chk("fl_spry", spry, 200);
    chk("fl_busy", busy, 0);
    @(negedge clk);
    chk("fl_busy2", busy, 0);

    // Frame and load while busy are ignored.
    do_frame(3, 3, 1'b1);
    repeat (4) @(negedge clk);
    chk("poke_busy", busy, 0);
    chk("poke_sprx", sprx, m_x);

    // Reset during MOVE_Y.
    @(negedge clk); frame = 1'b1; spd_x = 4'd3; spd_y = 4'd3;
    @(negedge clk); frame = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    chk("mid_rst_sprx", sprx, 0); chk("mid_rst_spry", spry, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_anim", anim_idx, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done !== 1'b0) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_done", seen_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
